// File: rtl/kim_counter_ctrl.sv
// Programmable up/down counter-timer: one-shot or auto-reload, with pause, abort and done pulse.
// All outputs registered; start accepted only in IDLE, pause holds the count, abort wins over start.
module kim_counter_ctrl #(
    parameter int CNT_DATA_WIDTH = 7,
    parameter int WRAP_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_DATA_WIDTH-1:0] cnt_val,
    input  logic [1:0]                mode,
    input  logic                      pause,
    input  logic                      abort,
    output logic [CNT_DATA_WIDTH-1:0] cnt,
    output logic                      busy,
    output logic                      done,
    output logic [WRAP_WIDTH-1:0]     wrap_cnt
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                    state_q;
    logic [CNT_DATA_WIDTH-1:0] cnt_q;
    logic [CNT_DATA_WIDTH-1:0] tv_q;
    logic [1:0]                md_q;
    logic                      busy_q;
    logic                      done_q;
    logic [WRAP_WIDTH-1:0]     wrap_q;

    logic [CNT_DATA_WIDTH-1:0] term_d;
    logic [CNT_DATA_WIDTH-1:0] reload_d;
    logic [CNT_DATA_WIDTH-1:0] step_d;

    // md_q[0]: down, md_q[1]: auto-reload
    always_comb begin
        term_d   = md_q[0] ? '0 : tv_q;
        reload_d = md_q[0] ? tv_q : '0;
        step_d   = md_q[0] ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tv_q    <= '0;
            md_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            tv_q    <= cnt_val;
                            md_q    <= mode;
                            cnt_q   <= mode[0] ? cnt_val : '0;
                            wrap_q  <= '0;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!pause) begin
                            if (cnt_q == term_d) begin
                                done_q <= 1'b1;
                                if (md_q[1]) begin
                                    cnt_q <= reload_d;
                                    if (wrap_q != {WRAP_WIDTH{1'b1}}) begin
                                        wrap_q <= wrap_q + 1'b1;
                                    end
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= step_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cnt      = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_kim_counter_ctrl.sv
// Bench for kim_counter_ctrl: cycle model feeds an expected-output queue, popped after each edge.
module tb_kim_counter_ctrl;

    localparam int W  = 7;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst, start, pause, abort;
    logic [W-1:0]  cnt_val;
    logic [1:0]    mode;
    logic [W-1:0]  cnt;
    logic          busy, done;
    logic [WW-1:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    kim_counter_ctrl #(.CNT_DATA_WIDTH(W), .WRAP_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .cnt_val(cnt_val), .mode(mode),
        .pause(pause), .abort(abort), .cnt(cnt), .busy(busy), .done(done),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    // reference state
    logic          m_run, m_done;
    logic [W-1:0]  m_cnt, m_tv;
    logic [1:0]    m_md;
    logic [WW-1:0] m_wrap;

    logic [W+WW+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] term;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_tv = 0; m_md = 0; m_wrap = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (abort) begin
                m_run = 0; m_cnt = 0;
            end else if (!m_run) begin
                if (start) begin
                    m_tv = cnt_val; m_md = mode; m_wrap = 0; m_run = 1;
                    m_cnt = mode[0] ? cnt_val : '0;
                end
            end else if (!pause) begin
                term = m_md[0] ? '0 : m_tv;
                if (m_cnt == term) begin
                    m_done = 1;
                    if (m_md[1]) begin
                        m_cnt = m_md[0] ? m_tv : '0;
                        if (m_wrap != 4'hF) m_wrap = m_wrap + 1;
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    m_cnt = m_md[0] ? W'(m_cnt - 1) : W'(m_cnt + 1);
                end
            end
        end
    endtask

    task automatic step();
        logic [W+WW+1:0] e;
        model_edge();
        exp_q.push_back({m_cnt, m_run, m_done, m_wrap});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", {cnt, busy, done, wrap_cnt}, e);
    endtask

    // start pulse, then steps until done (bounded); returns edges from start edge
    task automatic run_to_done(input logic [W-1:0] v, input logic [1:0] m, output int n);
        cnt_val = v; mode = m; start = 1; step(); start = 0;
        n = 0;
        while (n < 300) begin
            step(); n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    int n, nd;

    initial begin
        rst = 1; start = 0; pause = 0; abort = 0; cnt_val = 0; mode = 0;
        step(); step();
        check("rst_cnt", cnt, 0);
        check("rst_busy", busy, 0);
        rst = 0;

        // one-shot up to 100, with a start and input changes ignored during RUN
        cnt_val = 100; mode = 2'b00; start = 1; step(); start = 0;
        n = 0;
        while (n < 300) begin
            if (n == 10) begin start = 1; mode = 2'b11; cnt_val = 3; end
            else start = 0;
            step(); n++;
            if (done) break;
        end
        check("up100_lat", n, 101);
        check("up100_cnt", cnt, 100);
        step();
        check("up100_busy_after", busy, 0);
        check("up100_hold", cnt, 100);

        // one-shot down 5, then re-arm with 2
        run_to_done(5, 2'b01, n);
        check("dn5_lat", n, 6);
        check("dn5_cnt", cnt, 0);
        run_to_done(2, 2'b01, n);
        check("dn2_lat", n, 3);

        // auto-reload up 3
        cnt_val = 3; mode = 2'b10; start = 1; step(); start = 0;
        nd = 0;
        for (int i = 0; i < 19; i++) begin step(); if (done) nd++; end
        check("ar3_dones", nd, 4);
        check("ar3_wrap", wrap_cnt, 4);
        for (int i = 0; i < 60; i++) step();
        check("ar3_wrap_sat", wrap_cnt, 15);
        abort = 1; step(); abort = 0;
        check("abort_wrap_hold", wrap_cnt, 15);
        check("abort_busy", busy, 0);

        // cnt_val=0 auto-reload: done every cycle
        cnt_val = 0; mode = 2'b10; start = 1; step(); start = 0;
        nd = 0;
        for (int i = 0; i < 5; i++) begin step(); if (done) nd++; end
        check("ar0_dones", nd, 5);
        abort = 1; step(); abort = 0;

        // full-scale up count, no wrap
        run_to_done(7'h7F, 2'b00, n);
        check("up127_lat", n, 128);
        check("up127_cnt", cnt, 127);

        // pause for 7 cycles at cnt=4
        cnt_val = 10; mode = 2'b00; start = 1; step(); start = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin step(); n++; end
        check("pause_at4", cnt, 4);
        pause = 1;
        for (int i = 0; i < 7; i++) begin step(); n++; end
        check("pause_hold", cnt, 4);
        pause = 0;
        while (n < 100) begin step(); n++; if (done) break; end
        check("pause_lat", n, 18);

        // pause at terminal defers done
        cnt_val = 10; mode = 2'b00; start = 1; step(); start = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin step(); n++; end
        pause = 1;
        for (int i = 0; i < 3; i++) begin step(); n++; end
        check("pause_term_nodone", done, 0);
        pause = 0; step(); n++;
        check("pause_term_done", done, 1);
        check("pause_term_lat", n, 14);

        // abort mid-run, abort+start, reset mid-run
        cnt_val = 100; mode = 2'b00; start = 1; step(); start = 0;
        for (int i = 0; i < 50; i++) step();
        check("abort_at50", cnt, 50);
        abort = 1; step(); abort = 0;
        check("abort_cnt", cnt, 0);
        check("abort_done", done, 0);
        abort = 1; start = 1; step(); abort = 0; start = 0;
        check("abort_start_busy", busy, 0);
        step();
        check("abort_start_idle", busy, 0);
        cnt_val = 20; mode = 2'b11; start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) step();
        rst = 1; step(); rst = 0;
        check("rst_mid_all", {cnt, busy, done, wrap_cnt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kim_counter_ctrl.md
Name: kim_counter_ctrl

Overview:
- Parametrised successor to the single-shot up counter.
- Programmable counter/timer: terminal value and mode are latched on a start pulse.
- Modes: up or down, one-shot or auto-reload. Adds pause, abort, a done pulse, busy status and a saturating reload counter.
- Sits beside the counter top-level as the general-purpose event/delay generator for control FSMs.

Parameters:
- CNT_DATA_WIDTH, 7, width of cnt_val and cnt.
- WRAP_WIDTH, 4, width of wrap_cnt (reload counter).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  start pulse; accepted only in IDLE
- cnt_val  input  CNT_DATA_WIDTH  terminal value (up) / load value (down); sampled on accepted start
- mode  input  2  sampled on accepted start. bit0: 0=up, 1=down. bit1: 0=one-shot, 1=auto-reload.
- pause  input  1  level; holds count while high
- abort  input  1  pulse; terminates operation from any state
- cnt  output  CNT_DATA_WIDTH  current count
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse on each terminal event
- wrap_cnt  output  WRAP_WIDTH  number of auto-reloads since last start, saturating

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, busy=0, done=0, wrap_cnt=0, latched cnt_val/mode=0. Reset overrides every other input.
- Priority at every edge: rst > abort > start (IDLE only) > pause > terminal check > count.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- All outputs are registered. done defaults to 0 every cycle unless set below.

IDLE:
- start=1 and abort=0: latch cnt_val→tv and mode→md.
  - cnt loads 0 if up, tv if down.
  - wrap_cnt clears to 0.
  - state → RUN.
- start=0: cnt holds its last value; no change.

RUN, pause=1:
- cnt, state and wrap_cnt hold. No terminal detection; done=0.

RUN, pause=0, cnt≠term (term = tv for up, 0 for down):
- cnt increments by 1 (up) or decrements by 1 (down).

RUN, pause=0, cnt==term:
- done←1 for exactly one cycle.
- One-shot: state → IDLE, cnt holds term.
- Auto-reload: cnt reloads its start value (0 up, tv down); state stays RUN; wrap_cnt increments, saturating at all-ones.

Latency and timing:
- Start accepted at edge E0.
  - Up mode: cnt = n after edge En.
  - Down mode: cnt = tv − n after edge En.
- The terminal value is visible for one full cycle before done is asserted.
- One-shot up, tv=N, no pause: done is high in the cycle after edge E(N+1). busy is high after E0 through E(N+1)−, low after E(N+1).
- Auto-reload period: N+1 cycles between done pulses.

Boundary conditions:
- cnt_val=0: the first cycle after E0 is terminal, so done follows at E1. In auto-reload, done then pulses every cycle.
- cnt_val = 2^CNT_DATA_WIDTH−1: up count reaches all-ones with no overflow. Arithmetic is modulo 2^CNT_DATA_WIDTH, but terminal detection prevents any wrap.
- start while RUN: ignored. cnt_val/mode changes during RUN are ignored; the latched copies are used.
- abort (any state): state=IDLE, cnt=0, done=0, busy=0; wrap_cnt holds. abort together with start: abort wins, start is dropped.
- abort or pause in the same cycle as terminal: abort suppresses done; pause defers terminal detection until pause drops.
- rst mid-RUN: full reset values at the next edge; no done pulse.
- wrap_cnt saturates at 2^WRAP_WIDTH−1 and holds while reloads continue.

Test Plan:
- Reset, start=1 for one cycle with cnt_val=100, mode=00 → cnt runs 0..100; done pulses once exactly 101 cycles after the start edge; cnt holds 100; busy low afterwards.
- start with cnt_val=5, mode=01 → cnt 5,4,3,2,1,0; done one cycle after cnt=0; then IDLE with cnt=0. A second start with cnt_val=2 re-arms correctly.
- start with cnt_val=3, mode=10, run 20 cycles → done every 4 cycles; cnt sequence 0,1,2,3,0…; wrap_cnt 0→1→2→3→4 (not 5: the wrap_cnt=5 reload lands on a later edge).
- Continue auto-reload past 15 wraps with WRAP_WIDTH=4 → wrap_cnt saturates at 15.
- Up-count to 10; pause high for 7 cycles at cnt=4 → cnt holds 4; done is delayed by exactly 7 cycles. Pause asserted at cnt=10 delays done until pause drops.
- abort at cnt=50 (cnt_val=100) → next cycle cnt=0, busy=0, no done. Then abort+start together in IDLE → remains IDLE. Then rst mid-run → all outputs 0.
